// File: rtl/input_pkg.sv
// rtl/input_pkg.sv - key indices and axis encodings shared by the input conditioner
package input_pkg;

  localparam int KEY_NUM   = 6;
  localparam int KEY_ENTER = 0;
  localparam int KEY_PAUSE = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 3;
  localparam int KEY_LEFT  = 4;
  localparam int KEY_RIGHT = 5;

  typedef enum logic {
    AXIS_V_UP   = 1'b0,
    AXIS_V_DOWN = 1'b1
  } axis_v_e;

  typedef enum logic {
    AXIS_H_LEFT  = 1'b0,
    AXIS_H_RIGHT = 1'b1
  } axis_h_e;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one button channel: 2-FF sync, debounce, press pulse
// Optional auto-repeat pulses when KEY_AUTOREPEAT_EN is defined.
module key_debounce
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
`ifdef KEY_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 25000000
  , parameter int REPEAT_PERIOD = 5000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic key_level,
  output logic key_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  logic w_differ;
  logic w_accept;
  logic w_rise;

  assign w_differ = (r_sync2 != r_stable);
  assign w_accept = w_differ && (r_cnt == CNT_LAST);
  assign w_rise   = w_accept && r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      if (!w_differ || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_accept) begin
        r_stable <= r_sync2;
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0] r_rcnt;
  logic          w_next_stable;
  logic          w_repeat;

  assign w_next_stable = w_accept ? r_sync2 : r_stable;
  // Only repeat while the key stays held through this edge.
  assign w_repeat = r_stable && w_next_stable && (r_rcnt == REP_LAST);

  always_ff @(posedge clk) begin
    if (rst || !r_stable) begin
      r_rcnt <= '0;
    end else if (w_repeat) begin
      r_rcnt <= REP_RELOAD;
    end else begin
      r_rcnt <= r_rcnt + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_press <= 1'b0;
    end else begin
      r_press <= w_rise || w_repeat;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_press <= 1'b0;
    end else begin
      r_press <= w_rise;
    end
  end
`endif

  assign key_level = r_stable;
  assign key_press = r_press;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - six debounced buttons with last-pressed-wins direction arbitration
// Defining KEY_AUTOREPEAT_EN adds auto-repeat press pulses.
module input_conditioner
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
`ifdef KEY_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 25000000
  , parameter int REPEAT_PERIOD = 5000000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] btn_raw,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic               enter,
  output logic               pause,
  output logic               up,
  output logic               down,
  output logic               left,
  output logic               right
);

  axis_v_e r_last_v;
  axis_h_e r_last_h;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
      , .REPEAT_DELAY (REPEAT_DELAY)
      , .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_key (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw[g]),
      .key_level(key_level[g]),
      .key_press(key_press[g])
    );
  end

  // UP and LEFT win a same-cycle tie on their axis.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_v <= AXIS_V_UP;
      r_last_h <= AXIS_H_LEFT;
    end else begin
      if (key_press[KEY_UP]) begin
        r_last_v <= AXIS_V_UP;
      end else if (key_press[KEY_DOWN]) begin
        r_last_v <= AXIS_V_DOWN;
      end
      if (key_press[KEY_LEFT]) begin
        r_last_h <= AXIS_H_LEFT;
      end else if (key_press[KEY_RIGHT]) begin
        r_last_h <= AXIS_H_RIGHT;
      end
    end
  end

  assign enter = key_press[KEY_ENTER];
  assign pause = key_press[KEY_PAUSE];
  assign up    = key_level[KEY_UP]    & ~(key_level[KEY_DOWN]  & (r_last_v == AXIS_V_DOWN));
  assign down  = key_level[KEY_DOWN]  & ~(key_level[KEY_UP]    & (r_last_v == AXIS_V_UP));
  assign left  = key_level[KEY_LEFT]  & ~(key_level[KEY_RIGHT] & (r_last_h == AXIS_H_RIGHT));
  assign right = key_level[KEY_RIGHT] & ~(key_level[KEY_LEFT]  & (r_last_h == AXIS_H_LEFT));

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream stage of the game controller. Turns six raw, asynchronous, bouncy push-buttons into clean signals for the controller's enter/pause/up/down/left/right inputs.
- Each channel gets a 2-FF synchroniser, a debounce counter, press/release edge detection and opposite-direction arbitration.
- Directions leave as debounced levels; enter and pause leave as single-cycle press pulses, so the controller's state machine sees one event per press.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles the synchronised input must stay stable before it is accepted (10 ms at 50 MHz); legal range 2 or more.
- REPEAT_DELAY, 25000000, cycles held before the first auto-repeat pulse (only with the optional feature).
- REPEAT_PERIOD, 5000000, cycles between later auto-repeat pulses (only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_raw  in  6  raw buttons, active high; bit index per package constants
- key_level  out  6  debounced level per button
- key_press  out  6  one-cycle pulse per accepted rising edge (plus repeats, if enabled)
- enter  out  1  equal to key_press[KEY_ENTER]
- pause  out  1  equal to key_press[KEY_PAUSE]
- up, down, left, right  out  1 each  arbitrated direction levels

Behaviour:
- Clock and reset: single clock domain; rst is synchronous and active-high. While rst is sampled high, all flops clear: sync stages, stable levels, counters, last-axis registers, repeat counters. All outputs read 0 in the cycle after reset is sampled.
- Synchroniser: btn_raw passes through two flops per bit.
- Debounce, per channel:
  - stable register plus counter cnt, of width $clog2(DEBOUNCE_CYCLES).
  - If sync equals stable: cnt is set to 0.
  - Otherwise: cnt increments. When cnt equals DEBOUNCE_CYCLES-1 and sync still differs, stable takes sync and cnt is set to 0.
  - Any bounce back to the stable value restarts the count.
- Latency: a clean edge on btn_raw appears on key_level exactly DEBOUNCE_CYCLES+2 cycles after the first clock edge that samples it. Releases have the same latency.
- key_press[i] is registered. It is high for exactly one cycle: the first cycle key_level[i] reads 1. Releases produce no pulse.
- Button held through reset: a press is generated DEBOUNCE_CYCLES+2 cycles after rst deasserts.
- Direction arbitration, last-pressed-wins:
  - One register per axis: last_v in {UP, DOWN}, last_h in {LEFT, RIGHT}. It updates on key_press of that axis.
  - If both keys of an axis press in the same cycle, UP and LEFT take the register.
  - up = level[UP] and not (level[DOWN] and last_v == DOWN). down, left and right follow symmetrically.
  - Only one direction per axis is high at a time. Releasing the winner hands output to the held loser with zero extra latency; the outputs are combinational from registered state.
  - last_v and last_h reset to UP and LEFT.
- Independence: channels are fully independent. Simultaneous enter and pause presses both pulse in the same cycle; there is no arbitration between them.
- Counter sizing: counters saturate logic is not needed. cnt never exceeds DEBOUNCE_CYCLES-1 because it is set to 0 at that value.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat counter that runs while key_level is 1 and is set to 0 on release or reset.
  - An extra key_press pulse fires after REPEAT_DELAY cycles of continuous hold, measured from the initial press pulse, then every REPEAT_PERIOD cycles.
  - Repeat pulses update last_v and last_h like real presses.
- Undefined: no repeat logic is synthesised; exactly one pulse per press.

Decomposition:
- Package input_pkg:
  - KEY_NUM=6, with KEY_ENTER=0, KEY_PAUSE=1, KEY_UP=2, KEY_DOWN=3, KEY_LEFT=4, KEY_RIGHT=5.
  - Axis encodings: AXIS_V_UP=0, AXIS_V_DOWN=1, AXIS_H_LEFT=0, AXIS_H_RIGHT=1.
- Sub-module key_debounce: one channel containing sync, debounce, press pulse and optional repeat. Instantiated KEY_NUM times by generate.
- The top level holds only the arbitration registers and output mapping.

Test Plan (bench uses DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5):
- Clean press: btn_raw[0] 0→1 held 30 cycles → key_level[0] rises at cycle 10; enter pulses once for 1 cycle at cycle 10. Release → key_level[0] falls at cycle +10 with no pulse.
- Bounce: btn_raw[2] toggles high for 5 cycles, low for 1, repeated 4 times, then low → key_level[2], up and key_press all stay 0 throughout.
- Conflict: hold UP, then press DOWN 20 cycles later → up=1 then down=1, up=0. Release DOWN → up=1 again after 10 cycles. UP and DOWN pressed in the same cycle → up=1, down=0.
- Reset mid-count: btn_raw[1] high, rst pulsed at cycle 5 for 1 cycle → no pause pulse before cycle 5+1+10. Pause pulses exactly once at 10 cycles after rst drops.
- Simultaneous: btn_raw[0] and btn_raw[1] rise together → enter and pause pulse in the same cycle.
- KEY_AUTOREPEAT_EN defined: hold RIGHT for 40 cycles → key_press[5] at cycles 10, 30 and 35 (and 40 if still held). Macro undefined → only the pulse at cycle 10.
